// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit. Holds the PC, issues one outstanding
// word read at a time and presents the fetched instruction to the controller
// under a valid/ready handshake. The next PC comes from jump/branch/zero,
// sampled in the cycle the held instruction is accepted.
// Optional feature: define IFU_PERF_EN to build the fetch/redirect counters;
// without it both counter ports are tied to zero.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [5:0]  OP,
   output logic [5:0]  funct,
   output logic [31:0] pc_out,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] fetch_cnt,
   output logic [31:0] redirect_cnt
);

   typedef enum logic [1:0] {
      S_RST   = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_pc_out;
   logic        r_req;
   logic        r_valid;

   logic [31:0] w_seq_pc;
   logic [31:0] w_jump_pc;
   logic [31:0] w_br_pc;
   logic [31:0] w_next_pc;
   logic        w_accept;

   // Candidate successors of the held instruction (all modulo 2^32).
   assign w_seq_pc  = r_pc_out + 32'd4;
   assign w_jump_pc = {w_seq_pc[31:28], r_inst[25:0], 2'b00};
   assign w_br_pc   = w_seq_pc + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

   // A handshake only counts while an instruction is actually held.
   assign w_accept  = (r_state == S_HOLD) && inst_ready;

   // Next-PC select: jump beats a taken branch, otherwise fall through.
   always_comb begin
      w_next_pc = w_seq_pc;
      if (jump) begin
         w_next_pc = w_jump_pc;
      end else if (branch && zero) begin
         w_next_pc = w_br_pc;
      end else begin
         w_next_pc = w_seq_pc;
      end
   end

   // Fetch FSM with registered request/valid and held instruction/PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_RST;
         r_pc     <= RESET_PC;
         r_inst   <= 32'h0000_0000;
         r_pc_out <= RESET_PC;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_RST: begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
               r_valid <= 1'b0;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_inst   <= imem_rdata;
                  r_pc_out <= r_pc;
                  r_req    <= 1'b0;
                  r_valid  <= 1'b1;
                  r_state  <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  r_pc    <= w_next_pc;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_RST;
               r_pc    <= RESET_PC;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_pc;
   assign inst       = r_inst;
   assign inst_valid = r_valid;
   assign pc_out     = r_pc_out;
   assign OP         = r_inst[31:26];
   assign funct      = r_inst[5:0];

`ifdef IFU_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_redirect_cnt;
   logic        w_redirect;

   assign w_redirect = (w_next_pc != w_seq_pc);

   // Count accepted handshakes and those that leave the sequential path.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_cnt    <= 32'h0000_0000;
         r_redirect_cnt <= 32'h0000_0000;
      end else if (w_accept) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_redirect) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         end
      end
   end

   assign fetch_cnt    = r_fetch_cnt;
   assign redirect_cnt = r_redirect_cnt;
`else
   assign fetch_cnt    = 32'h0000_0000;
   assign redirect_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a randomised driver plays memory and
// controller, a transaction-level model predicts request addresses and held
// instructions, and a monitor compares them against the DUT each cycle.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [5:0]  OP;
   logic [5:0]  funct;
   logic [31:0] pc_out;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .OP(OP), .funct(funct), .pc_out(pc_out),
      .jump(jump), .branch(branch), .zero(zero),
      .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fetch_t;

   int checks   = 0;
   int failures = 0;
   int n_accept = 0;

   // instruction memory, filled lazily with random words
   logic [31:0] mem [logic [31:0]];

   // driver configuration (set by the sequencer at negedge)
   int          rst_cycles      = 0;
   int          cfg_ack_delay   = -1;
   int          cfg_ready_delay = -1;
   logic        cfg_rst_addr_en = 1'b0;
   logic [31:0] cfg_rst_addr    = 32'h0000_0040;
   logic [2:0]  ctrl_q [$];

   function automatic logic [31:0] get_word(logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   // Reference next-PC from the architectural rules.
   function automatic logic [31:0] ref_next(logic [31:0] pc, logic [31:0] ins,
                                            logic j, logic b, logic z);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (b && z) begin
         off = $signed(ins[15:0]);
         return seq + 32'(off * 4);
      end
      return seq;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(string name);
      checks++;
      failures++;
      $display("FAIL %s @%0t", name, $time);
   endtask

   // Driver: memory responder and controller, acting just after each edge.
   initial begin : driver
      logic in_req, in_hold, ack_in_rst;
      int   wait_cnt, hold_cnt;
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
      inst_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
      in_req = 1'b0; in_hold = 1'b0; ack_in_rst = 1'b0;
      wait_cnt = 0; hold_cnt = 0;
      forever begin
         @(posedge clk); #1;
         // memory side
         if (imem_req) begin
            if (!in_req) begin
               in_req   = 1'b1;
               wait_cnt = (cfg_ack_delay < 0) ? int'($urandom_range(0, 3)) : cfg_ack_delay;
            end
            if (wait_cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = get_word(imem_addr);
               in_req     = 1'b0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = $urandom;
               wait_cnt--;
            end
         end else begin
            in_req     = 1'b0;
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
         end
         // controller side
         if (inst_valid) begin
            if (!in_hold) begin
               in_hold  = 1'b1;
               hold_cnt = (cfg_ready_delay < 0) ?
                          (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4))) :
                          cfg_ready_delay;
            end
            if (hold_cnt == 0) begin
               inst_ready = 1'b1;
               in_hold    = 1'b0;
               if (ctrl_q.size() > 0) {jump, branch, zero} = ctrl_q.pop_front();
               else {jump, branch, zero} = 3'($urandom);
            end else begin
               inst_ready = 1'b0;
               hold_cnt--;
               {jump, branch, zero} = 3'($urandom);
            end
         end else begin
            in_hold    = 1'b0;
            inst_ready = 1'($urandom_range(0, 1));
            {jump, branch, zero} = 3'($urandom);
         end
         // reset control
         if (ack_in_rst) begin
            imem_ack   = 1'b1;
            ack_in_rst = 1'b0;
            rst        = 1'b0;
         end else if (rst_cycles > 0) begin
            rst = 1'b1;
            rst_cycles--;
         end else if (cfg_rst_addr_en && imem_req && imem_addr == cfg_rst_addr) begin
            rst             = 1'b1;
            imem_ack        = 1'b1;
            in_req          = 1'b0;
            cfg_rst_addr_en = 1'b0;
            ack_in_rst      = 1'b1;
         end else begin
            rst = 1'b0;
         end
      end
   end

   // Monitor: model + scoreboard, sampling mid-cycle.
   initial begin : monitor
      logic [31:0] exp_addr_q [$];
      fetch_t      exp_inst_q [$];
      logic        started, rst_prev, expect_req, prev_ack;
      logic [31:0] m_fetch, m_redir, a, nxt;
      fetch_t      e;
      started = 1'b0; rst_prev = 1'b0; expect_req = 1'b0; prev_ack = 1'b0;
      m_fetch = 32'h0; m_redir = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            started = 1'b1;
            rst_prev = 1'b1;
            expect_req = 1'b0;
            prev_ack = 1'b0;
            exp_addr_q.delete();
            exp_inst_q.delete();
            exp_addr_q.push_back(RESET_PC);
            m_fetch = 32'h0;
            m_redir = 32'h0;
         end else if (started && rst_prev) begin
            chk("rst_req", {31'h0, imem_req}, 32'h0);
            chk("rst_valid", {31'h0, inst_valid}, 32'h0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_inst", inst, 32'h0);
            chk("rst_pc_out", pc_out, RESET_PC);
            chk("rst_op_funct", {20'h0, OP, funct}, 32'h0);
            chk("rst_fetch_cnt", fetch_cnt, 32'h0);
            chk("rst_redirect_cnt", redirect_cnt, 32'h0);
            rst_prev = 1'b0;
            expect_req = 1'b1;
         end else if (started) begin
            if (expect_req) begin
               chk("req_after_accept", {31'h0, imem_req}, 32'h1);
               chk("valid_low_in_fetch", {31'h0, inst_valid}, 32'h0);
            end
            if (prev_ack) begin
               chk("valid_after_ack", {31'h0, inst_valid}, 32'h1);
               chk("req_drop_after_ack", {31'h0, imem_req}, 32'h0);
            end
            expect_req = 1'b0;
            prev_ack = 1'b0;
            if (imem_req) begin
               if (exp_addr_q.size() == 0) flag_fail("unexpected_req");
               else begin
                  chk("imem_addr", imem_addr, exp_addr_q[0]);
                  if (imem_ack) begin
                     a = exp_addr_q.pop_front();
                     exp_inst_q.push_back({a, get_word(a)});
                     prev_ack = 1'b1;
                  end
               end
            end
            if (inst_valid) begin
               if (exp_inst_q.size() == 0) flag_fail("unexpected_valid");
               else begin
                  e = exp_inst_q[0];
                  chk("inst", inst, e.ins);
                  chk("pc_out", pc_out, e.pc);
                  chk("op_funct", {20'h0, OP, funct}, {20'h0, e.ins[31:26], e.ins[5:0]});
                  if (inst_ready) begin
                     chk("fetch_cnt", fetch_cnt, m_fetch);
                     chk("redirect_cnt", redirect_cnt, m_redir);
                     nxt = ref_next(e.pc, e.ins, jump, branch, zero);
`ifdef IFU_PERF_EN
                     m_fetch = m_fetch + 32'd1;
                     if (nxt != e.pc + 32'd4) m_redir = m_redir + 32'd1;
`endif
                     void'(exp_inst_q.pop_front());
                     exp_addr_q.push_back(nxt);
                     expect_req = 1'b1;
                     n_accept++;
                  end
               end
            end
         end
      end
   end

   task automatic wait_accepts(int k, int limit, string name);
      int target;
      int cyc;
      target = n_accept + k;
      cyc = 0;
      while (n_accept < target && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      if (n_accept < target) flag_fail({"timeout_", name});
   endtask

   // Sequencer: directed scenarios, then a randomised soak.
   initial begin : sequencer
      // sequential fetch, branch taken/not taken, jump beats branch
      mem[32'h0000_0010] = 32'h1000_FFFD;
      mem[32'h0000_0014] = 32'h0800_0040;
      cfg_ack_delay   = 1;
      cfg_ready_delay = 0;
      ctrl_q = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011,
                 3'b000, 3'b000, 3'b010, 3'b111};
      rst_cycles = 2;
      wait_accepts(9, 300, "directed_flow");

      // backpressure and slow memory
      cfg_ack_delay   = 3;
      cfg_ready_delay = 5;
      wait_accepts(3, 300, "backpressure");

      // wrap-around through 0xFFFF_FFFC
      @(negedge clk);
      mem[32'h0000_0000] = 32'h1000_FFFE;
      cfg_ack_delay   = 0;
      cfg_ready_delay = 0;
      ctrl_q = '{3'b011, 3'b000, 3'b000};
      rst_cycles = 1;
      wait_accepts(3, 300, "wrap");

      // reset while fetching 0x40, with an ack in the same cycle
      @(negedge clk);
      mem[32'h0000_0000] = 32'h0800_0010;
      ctrl_q = '{3'b100};
      cfg_rst_addr_en = 1'b1;
      rst_cycles = 1;
      wait_accepts(2, 300, "mid_reset");
      if (cfg_rst_addr_en) flag_fail("mid_reset_not_hit");

      // randomised soak with occasional resets
      cfg_ack_delay   = -1;
      cfg_ready_delay = -1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) rst_cycles = int'($urandom_range(1, 2));
      end
      wait_accepts(1, 200, "soak_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
